icache_controller: RTL and testbench

Direct-mapped instruction cache and controller in front of the 128-bit-block instruction memory. Serves 32-bit fetches to the IF stage. Hits complete combinationally in the same cycle. On a miss, the FSM sequences a single block read on the memory read/busywait handshake, fills the line, then replays the fetch. The IF stage stalls on cpu_busywait.

---
 rtl/icache_controller.sv | 70 +++++++
 tb/tb_icache_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/icache_controller.sv
// icache_controller: direct-mapped instruction cache with a miss FSM (IDLE -> MEM_READ -> UPDATE)
// Ports: clock/reset (sync, active-high); cpu_read, cpu_address in / cpu_instruction, cpu_busywait out (IF side);
//        mem_read, mem_address out / mem_readinst, mem_busywait in (128-bit block memory side).
module icache_controller #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS = 28 - INDEX_BITS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_read,
  input  logic [31:0]  cpu_address,
  output logic [31:0]  cpu_instruction,
  output logic         cpu_busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readinst,
  input  logic         mem_busywait
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam logic [1:0] IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2;
  logic [1:0] state;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [127:0] data [LINES];
  logic [127:0] fill;
  logic [27:0] miss_addr;
  logic [INDEX_BITS-1:0] index, miss_index;
  logic [TAG_BITS-1:0] tag, miss_tag;
  logic [1:0] w;
  logic hit, unused_byte;
  assign index = cpu_address[INDEX_BITS+3:4];
  assign tag = cpu_address[31:INDEX_BITS+4];
  assign w = cpu_address[3:2];
  assign unused_byte = ^cpu_address[1:0];
  assign miss_index = miss_addr[INDEX_BITS-1:0];
  assign miss_tag = miss_addr[27:INDEX_BITS];
  assign hit = cpu_read & valid[index] & (tags[index] == tag);
  assign cpu_instruction = hit ? data[index][32*w +: 32] : 32'h0;
  assign cpu_busywait = (state == IDLE) ? cpu_read & ~hit : 1'b1;
  assign mem_read = state == MEM_READ;
  // miss_addr doubles as the memory address and stays put outside MEM_READ
  assign mem_address = miss_addr;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      miss_addr <= '0;
      fill <= '0;
    end else case (state)
      IDLE: if (cpu_read & ~hit) begin
        miss_addr <= cpu_address[31:4];
        state <= MEM_READ;
      end
      MEM_READ: if (!mem_busywait) begin
        fill <= mem_readinst;
        state <= UPDATE;
      end
      UPDATE: begin
        valid[miss_index] <= 1'b1;
        state <= IDLE;
      end
      default: state <= IDLE;
    endcase
  // tag/data arrays carry no reset; a reset during UPDATE must not commit the line
  always_ff @(posedge clock)
    if (!reset && state == UPDATE) begin
      tags[miss_index] <= miss_tag;
      data[miss_index] <= fill;
    end
endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: randomized self-checking bench with a line-level cache model and latency-programmable memory
module tb_icache_controller;
  logic clk = 0, reset = 1, cpu_read = 0, mem_read, mem_busywait, cpu_busywait;
  logic [31:0] cpu_address = 0, cpu_instruction;
  logic [27:0] mem_address;
  logic [127:0] mem_readinst;
  int lat = 1, cnt = 0, n_chk = 0, n_err = 0;
  bit mv [8];
  logic [24:0] mt [8];
  int cyc, pulses, gap, mingap;
  logic prev;
  logic [31:0] a;
  logic [127:0] blk;

  icache_controller dut (
    .clock(clk), .reset(reset), .cpu_read(cpu_read), .cpu_address(cpu_address),
    .cpu_instruction(cpu_instruction), .cpu_busywait(cpu_busywait), .mem_read(mem_read),
    .mem_address(mem_address), .mem_readinst(mem_readinst), .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mem_data(input logic [27:0] b);
    logic [127:0] r;
    if (b == 28'h0) return {32'h0000F613, 32'h12345678, 32'h9ABCDEF0, 32'h8F108093};
    for (int i = 0; i < 4; i++) r[32*i +: 32] = {b, i[3:0]} * 32'h9E3779B1 + i;
    return r;
  endfunction

  // memory: busy for lat-1 cycles of an asserted read, then data valid
  always @(posedge clk) cnt <= mem_read ? cnt + 1 : 0;
  assign mem_busywait = mem_read && (cnt < lat - 1);
  assign mem_readinst = mem_data(mem_address);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] ad);
    logic [127:0] d;
    d = mem_data(ad[31:4]);
    return d[32*ad[3:2] +: 32];
  endfunction

  task automatic fetch(input logic [31:0] ad, input int l);
    int c, mrc, p;
    logic pr;
    bit exp_hit;
    lat = l;
    cpu_read = 1;
    cpu_address = ad;
    #1;
    exp_hit = mv[ad[6:4]] && mt[ad[6:4]] == ad[31:7];
    c = 0; mrc = 0; p = 0; pr = 0;
    if (!exp_hit) begin
      chk("miss_busy", cpu_busywait, 1);
      while (cpu_busywait && c < 100) begin
        if (mem_read) begin
          mrc++;
          if (!pr) p++;
          chk("miss_addr", mem_address, ad[31:4]);
        end
        pr = mem_read;
        tick;
        c++;
      end
      chk("miss_cycles", c, l + 2);
      chk("miss_memrd_cycles", mrc, l);
      chk("miss_pulses", p, 1);
      mv[ad[6:4]] = 1;
      mt[ad[6:4]] = ad[31:7];
    end
    chk("fetch_busy", cpu_busywait, 0);
    chk("fetch_memrd", mem_read, 0);
    chk("fetch_instr", cpu_instruction, word_of(ad));
    if (exp_hit) tick;
  endtask

  initial begin
    foreach (mv[i]) mv[i] = 0;
    tick;
    tick;
    cpu_read = 1;
    #1;
    chk("rst_busy", cpu_busywait, 1);
    chk("rst_instr", cpu_instruction, 0);
    chk("rst_memrd", mem_read, 0);
    chk("rst_maddr", mem_address, 0);
    cpu_read = 0;
    #1;
    chk("rst_busy_idle", cpu_busywait, 0);
    reset = 0;
    tick;
    fetch(32'h0, 4);
    chk("first_instr", cpu_instruction, 32'h8F108093);
    fetch(32'hC, 4);
    chk("hit_instr", cpu_instruction, 32'h0000F613);
    fetch(32'h80, 2);
    fetch(32'h0, 2);
    // address changes mid-miss: fill uses the latched block, new address misses afterwards
    lat = 3;
    cpu_read = 1;
    cpu_address = 32'h10;
    #1;
    cyc = 0; pulses = 0; gap = 0; mingap = 99; prev = 0;
    while (cpu_busywait && cyc < 100) begin
      if (mem_read) begin
        if (!prev) begin
          pulses++;
          if (pulses > 1 && gap < mingap) mingap = gap;
        end
        chk("chg_maddr", mem_address, pulses == 1 ? 32'h1 : 32'h2);
        gap = 0;
      end else gap++;
      prev = mem_read;
      tick;
      cyc++;
      if (cyc == 2) begin
        cpu_address = 32'h20;
        #1;
      end
    end
    chk("chg_cycles", cyc, 10);
    chk("chg_pulses", pulses, 2);
    chk("chg_gap", mingap >= 2, 1);
    chk("chg_instr", cpu_instruction, word_of(32'h20));
    mv[1] = 1; mt[1] = 0;
    mv[2] = 1; mt[2] = 0;
    fetch(32'h14, 1);
    // reset while in MEM_READ abandons the fill
    lat = 5;
    cpu_read = 1;
    cpu_address = 32'h30;
    #1;
    tick;
    tick;
    chk("rst_pre_memrd", mem_read, 1);
    reset = 1;
    tick;
    chk("rst_mid_memrd", mem_read, 0);
    chk("rst_mid_busy", cpu_busywait, 1);
    chk("rst_mid_instr", cpu_instruction, 0);
    reset = 0;
    foreach (mv[i]) mv[i] = 0;
    fetch(32'h30, 2);
    fetch(32'h0, 1);
    cpu_read = 0;
    repeat (10) begin
      cpu_address = $urandom;
      #1;
      chk("idle_busy", cpu_busywait, 0);
      chk("idle_memrd", mem_read, 0);
      chk("idle_instr", cpu_instruction, 0);
      tick;
    end
    fetch(32'h34, 3);
    repeat (60) begin
      a = $urandom & 32'h0000_01FC;
      if ($urandom_range(0, 3) == 0) a[31:28] = 4'($urandom_range(1, 15));
      fetch(a, $urandom_range(1, 5));
      if ($urandom_range(0, 3) == 0) begin
        cpu_read = 0;
        tick;
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
